// File: rtl/key_pkg.sv
// key_pkg
// Shared types and constants for the key debounce blocks.
//   state_t     : debounce FSM state (IDLE, DEBOUNCE)
//   CNT_MAX_50M : 20 ms debounce window at a 50 MHz sys_clk
//   CNT_MAX_SIM : short window used in simulation
package key_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      DEBOUNCE = 1'b1
   } state_t;

   localparam logic [19:0] CNT_MAX_50M = 20'd999_999;
   localparam logic [19:0] CNT_MAX_SIM = 20'd24;

endpackage

// File: rtl/key_rr_arb.sv
// key_rr_arb
// Combinational round-robin priority search. Returns the first set bit of
// pending, starting at index ptr and wrapping past the top back to 0.
//   pending : request vector
//   ptr     : index that has highest priority this cycle
//   grant   : index of the winning request (0 when valid is low)
//   valid   : at least one request is set
module key_rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pending,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          valid
);

   int idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!valid && pending[idx[PW-1:0]]) begin
            valid = 1'b1;
            grant = idx[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/key_mux_filter.sv
// key_mux_filter
// Debounces a bank of active-low keys with a single shared counter. A key
// whose synchronized level differs from its committed level is granted the
// counter in round-robin order; once the new level holds for CNT_MAX cycles
// the committed level toggles and a one-cycle press/release pulse is emitted.
//   sys_clk     : system clock
//   sys_rst     : synchronous reset, active-high
//   key_in      : raw key pins, active-low, asynchronous
//   key_state   : debounced level per key (1 = released)
//   key_flag    : one-cycle pulse on a confirmed press
//   key_release : one-cycle pulse on a confirmed release
//   busy        : a key is currently being debounced
module key_mux_filter
   import key_pkg::*;
#(
   parameter int               KEY_NUM = 4,
   parameter int               CNT_W   = 20,
   parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_50M
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_flag,
   output logic [KEY_NUM-1:0] key_release,
   output logic               busy
);

   localparam int PW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

   logic [KEY_NUM-1:0] sync1, key_sync, pending;
   state_t             state, state_n;
   logic [PW-1:0]      sel, sel_n, ptr, ptr_n, sel_inc, grant;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               grant_valid, commit;

   assign pending = key_sync ^ key_state;
   assign busy    = (state == DEBOUNCE);
   // Wrap explicitly so non-power-of-two key counts stay in range.
   assign sel_inc = (sel == PW'(KEY_NUM - 1)) ? '0 : sel + 1'b1;

   key_rr_arb #(.N(KEY_NUM), .PW(PW)) u_arb (
      .pending (pending),
      .ptr     (ptr),
      .grant   (grant),
      .valid   (grant_valid)
   );

   always_comb begin
      state_n = state;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               sel_n   = grant;
               cnt_n   = '0;
               state_n = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            // Bounce back to the committed level aborts without a pulse.
            if (key_sync[sel] == key_state[sel]) begin
               state_n = IDLE;
               ptr_n   = sel_inc;
            end else if (cnt == CNT_MAX - 1'b1) begin
               commit  = 1'b1;
               state_n = IDLE;
               ptr_n   = sel_inc;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1       <= '1;
         key_sync    <= '1;
         key_state   <= '1;
         key_flag    <= '0;
         key_release <= '0;
         state       <= IDLE;
         sel         <= '0;
         ptr         <= '0;
         cnt         <= '0;
      end else begin
         sync1       <= key_in;
         key_sync    <= sync1;
         state       <= state_n;
         sel         <= sel_n;
         ptr         <= ptr_n;
         cnt         <= cnt_n;
         key_flag    <= '0;
         key_release <= '0;
         if (commit) begin
            key_state[sel] <= ~key_state[sel];
            // Old level 1 means the key just went down.
            if (key_state[sel]) key_flag[sel]    <= 1'b1;
            else                key_release[sel] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_key_mux_filter.sv
// tb_key_mux_filter
// Directed bench for key_mux_filter (KEY_NUM=4, CNT_MAX=24). A timestamp-based
// model predicts outputs every cycle; scenario checks pin pulse edges by hand.
module tb_key_mux_filter;
   import key_pkg::*;

   localparam int N  = 4;
   localparam int CM = 24;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [3:0] key_in  = 4'b0101;
   logic [3:0] key_state, key_flag, key_release;
   logic       busy;

   key_mux_filter #(.KEY_NUM(N), .CNT_W(20), .CNT_MAX(CNT_MAX_SIM)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_flag    (key_flag),
      .key_release (key_release),
      .busy        (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state
   logic [3:0] m_s1, m_sync, m_state, m_flag, m_rel, m_pend;
   logic       m_busy;
   int         m_sel, m_ptr, m_start, m_k;

   typedef struct {
      int         t;
      logic [3:0] f;
      logic [3:0] r;
   } ev_t;
   ev_t evq[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a granted key commits exactly CM edges after its grant unless its
   // synchronized level returns to the committed level first.
   initial begin
      forever begin
         @(posedge sys_clk);
         cyc++;
         if (sys_rst) begin
            m_s1 = 4'hF; m_sync = 4'hF; m_state = 4'hF;
            m_flag = 4'h0; m_rel = 4'h0; m_busy = 1'b0;
            m_ptr = 0; m_sel = 0; m_start = 0;
         end else begin
            m_flag = 4'h0;
            m_rel  = 4'h0;
            if (m_busy) begin
               if (m_sync[m_sel] == m_state[m_sel]) begin
                  m_busy = 1'b0;
                  m_ptr  = (m_sel + 1) % N;
               end else if (cyc - m_start == CM) begin
                  m_state[m_sel] = ~m_state[m_sel];
                  if (m_state[m_sel] == 1'b0) m_flag[m_sel] = 1'b1;
                  else                        m_rel[m_sel]  = 1'b1;
                  m_busy = 1'b0;
                  m_ptr  = (m_sel + 1) % N;
               end
            end else begin
               m_pend = m_sync ^ m_state;
               for (int i = 0; i < N; i++) begin
                  m_k = (m_ptr + i) % N;
                  if (!m_busy && m_pend[m_k]) begin
                     m_busy  = 1'b1;
                     m_sel   = m_k;
                     m_start = cyc;
                  end
               end
            end
            m_sync = m_s1;
            m_s1   = key_in;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge sys_clk);
         chk("key_state", key_state, m_state);
         chk("key_flag", key_flag, m_flag);
         chk("key_release", key_release, m_rel);
         chk("busy", busy, m_busy);
         if ((key_flag | key_release) != 4'h0)
            evq.push_back('{cyc, key_flag, key_release});
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge sys_clk);
      #1;
   endtask

   task automatic chk_ev(string name, int qs, int k, int base, int edge_exp,
                         logic [3:0] f_exp, logic [3:0] r_exp);
      if (evq.size() <= qs + k) begin
         total++;
         bad++;
         $display("FAIL %s: event %0d missing, required at edge %0d", name, k, edge_exp);
      end else begin
         chk({name, " edge"}, evq[qs+k].t - base, edge_exp);
         chk({name, " flag"}, evq[qs+k].f, f_exp);
         chk({name, " release"}, evq[qs+k].r, r_exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "timeout");
   end

   int qs, base, n2;

   initial begin
      // reset with keys 1 and 3 held
      repeat (3) begin
         step(1);
         chk("rst key_state", key_state, 4'hF);
         chk("rst key_flag", key_flag, 4'h0);
         chk("rst key_release", key_release, 4'h0);
         chk("rst busy", busy, 1'b0);
      end
      sys_rst = 1'b0;
      key_in  = 4'hF;
      step(5);

      // contention: keys 0, 2, 3 together, ptr = 0 after reset
      qs = evq.size(); base = cyc + 1;
      key_in = 4'b0010;
      step(90);
      chk("cont count", evq.size() - qs, 3);
      chk_ev("cont k0", qs, 0, base, 26, 4'b0001, 4'b0000);
      chk_ev("cont k2", qs, 1, base, 51, 4'b0100, 4'b0000);
      chk_ev("cont k3", qs, 2, base, 76, 4'b1000, 4'b0000);
      chk("cont state", key_state, 4'b0010);
      key_in = 4'hF;
      step(90);
      chk("cont rel state", key_state, 4'hF);

      // clean press of key 1, then release 200 cycles after the press
      qs = evq.size(); base = cyc + 1;
      key_in = 4'b1101;
      step(30);
      chk("press count", evq.size() - qs, 1);
      chk_ev("press k1", qs, 0, base, 26, 4'b0010, 4'b0000);
      chk("press state", key_state, 4'b1101);
      step(170);
      qs = evq.size(); base = cyc + 1;
      key_in = 4'hF;
      step(30);
      chk_ev("release k1", qs, 0, base, 26, 4'b0000, 4'b0010);
      chk("release state", key_state, 4'hF);

      // bounce on key 2, then hold pressed
      qs = evq.size();
      for (int i = 0; i < 10; i++) begin
         key_in[2] = 1'($urandom_range(0, 1));
         step(1);
      end
      key_in[2] = 1'b0;
      step(40);
      n2 = 0;
      for (int i = qs; i < evq.size(); i++)
         if (evq[i].f[2]) n2++;
      chk("bounce pulses", n2, 1);
      chk("bounce state", key_state, 4'b1011);
      key_in = 4'hF;
      step(30);
      chk("bounce rel state", key_state, 4'hF);

      // round robin: last commit was key 2, so key 3 goes before key 0
      qs = evq.size(); base = cyc + 1;
      key_in = 4'b0110;
      step(60);
      chk("rr count", evq.size() - qs, 2);
      chk_ev("rr k3", qs, 0, base, 26, 4'b1000, 4'b0000);
      chk_ev("rr k0", qs, 1, base, 51, 4'b0001, 4'b0000);
      key_in = 4'hF;
      step(60);

      // reset in the middle of a key 0 debounce
      qs = evq.size(); base = cyc + 1;
      key_in = 4'b1110;
      step(15);
      sys_rst = 1'b1;
      step(2);
      chk("midrst pulses", evq.size() - qs, 0);
      chk("midrst state", key_state, 4'hF);
      sys_rst = 1'b0;
      qs = evq.size(); base = cyc + 1;
      step(30);
      chk("post rst count", evq.size() - qs, 1);
      chk_ev("post rst k0", qs, 0, base, 26, 4'b0001, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
